// File: rtl/hazard_if.sv
// Hazard-controller bus: ID/EX hazard inputs and the pipeline register controls.
// The master drives the hazard inputs; the slave (controller) drives the controls.
interface hazard_if #(
  parameter int unsigned PERF_W = 16
);
  logic [4:0]        ID_rs1;
  logic [4:0]        ID_rs2;
  logic              ID_uses_rs1;
  logic              ID_uses_rs2;
  logic              EX_memread;
  logic [4:0]        EX_rd;
  logic              EX_branch_taken;
  logic              EX_md_start;
  logic              pc_write;
  logic              ifid_write;
  logic              ifid_flush;
  logic              idex_bubble;
  logic              idex_write;
  logic              ex_hold;
  logic              exmem_bubble;
  logic [PERF_W-1:0] stall_cycles;

  modport master (
    output ID_rs1, ID_rs2, ID_uses_rs1, ID_uses_rs2, EX_memread, EX_rd, EX_branch_taken,
           EX_md_start,
    input  pc_write, ifid_write, ifid_flush, idex_bubble, idex_write, ex_hold, exmem_bubble,
           stall_cycles
  );

  modport slave (
    input  ID_rs1, ID_rs2, ID_uses_rs1, ID_uses_rs2, EX_memread, EX_rd, EX_branch_taken,
           EX_md_start,
    output pc_write, ifid_write, ifid_flush, idex_bubble, idex_write, ex_hold, exmem_bubble,
           stall_cycles
  );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline hazard sequencer: load-use stall, taken-branch flush, multi-cycle mul/div hold,
// plus a saturating count of cycles in which the PC was frozen.
module hazard_controller #(
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned PERF_W     = 16
) (
  input logic     clk,
  input logic     rst_n,
  hazard_if.slave hz
);

  typedef enum logic [0:0] {StRun, StMdBusy} state_e;

  // MD_BUSY cycles that follow the start cycle; total stall is MULDIV_LAT-1 cycles.
  localparam int unsigned MdBusyCycles = (MULDIV_LAT > 2) ? MULDIV_LAT - 2 : 0;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PERF_W-1:0] stall_q, stall_d;

  logic load_use;
  logic pc_we, ifid_we, ifid_fl, idex_bub, idex_we, hold, exmem_bub;

  assign load_use = hz.EX_memread && (hz.EX_rd != 5'd0) &&
                    ((hz.ID_uses_rs1 && (hz.ID_rs1 == hz.EX_rd)) ||
                     (hz.ID_uses_rs2 && (hz.ID_rs2 == hz.EX_rd)));

  always_comb begin
    pc_we     = 1'b1;
    ifid_we   = 1'b1;
    ifid_fl   = 1'b0;
    idex_bub  = 1'b0;
    idex_we   = 1'b1;
    hold      = 1'b0;
    exmem_bub = 1'b0;
    state_d   = state_q;
    cnt_d     = cnt_q;

    if (!rst_n) begin
      pc_we     = 1'b0;
      ifid_we   = 1'b0;
      ifid_fl   = 1'b1;
      idex_bub  = 1'b1;
      exmem_bub = 1'b1;
      state_d   = StRun;
      cnt_d     = '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (hz.EX_branch_taken) begin
            ifid_fl  = 1'b1;
            idex_bub = 1'b1;
          end else if (hz.EX_md_start && (MULDIV_LAT > 1)) begin
            pc_we     = 1'b0;
            ifid_we   = 1'b0;
            idex_we   = 1'b0;
            hold      = 1'b1;
            exmem_bub = 1'b1;
            if (MdBusyCycles != 0) begin
              state_d = StMdBusy;
              cnt_d   = CNT_W'(MdBusyCycles);
            end
          end else if (load_use) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_bub = 1'b1;
          end
        end
        StMdBusy: begin
          pc_we     = 1'b0;
          ifid_we   = 1'b0;
          idex_we   = 1'b0;
          hold      = 1'b1;
          exmem_bub = 1'b1;
          // cnt_q is the number of busy cycles left including this one
          if (cnt_q <= CNT_W'(1)) begin
            state_d = StRun;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = StRun;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    stall_d = stall_q;
    if (!rst_n) begin
      stall_d = '0;
    end else if (!pc_we && (stall_q != {PERF_W{1'b1}})) begin
      stall_d = stall_q + PERF_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StRun;
      cnt_q   <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= stall_d;
    end
  end

  assign hz.pc_write     = pc_we;
  assign hz.ifid_write   = ifid_we;
  assign hz.ifid_flush   = ifid_fl;
  assign hz.idex_bubble  = idex_bub;
  assign hz.idex_write   = idex_we;
  assign hz.ex_hold      = hold;
  assign hz.exmem_bubble = exmem_bub;
  assign hz.stall_cycles = stall_q;

endmodule

// File: tb/tb_hazard_controller.sv
// Randomised + directed bench for hazard_controller against a stall-budget reference model.
module tb_hazard_controller;

  localparam int unsigned Lat   = 4;
  localparam int unsigned PerfW = 4;
  localparam int unsigned SatMax = (1 << PerfW) - 1;

  // {pc_write, ifid_write, ifid_flush, idex_bubble, idex_write, ex_hold, exmem_bubble}
  localparam logic [6:0] CtlReset = 7'b0011101;
  localparam logic [6:0] CtlIdle  = 7'b1100100;
  localparam logic [6:0] CtlFlush = 7'b1111100;
  localparam logic [6:0] CtlMd    = 7'b0000011;
  localparam logic [6:0] CtlLu    = 7'b0001100;

  logic clk = 1'b0;
  logic rst_n;

  hazard_if #(.PERF_W(PerfW)) hz ();

  hazard_controller #(
    .MULDIV_LAT (Lat),
    .CNT_W      (4),
    .PERF_W     (PerfW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .hz    (hz)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: stall cycles still owed to an in-flight mul/div, and the perf count.
  int m_md_left  = 0;
  int m_cnt      = 0;
  bit m_cnt_known = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic bit model_lu(input bit mr, input int rd, input int r1, input int r2,
                                  input bit u1, input bit u2);
    return mr && rd != 0 && ((u1 && r1 == rd) || (u2 && r2 == rd));
  endfunction

  // Drive one cycle of inputs, check outputs mid-cycle, then advance the model over the edge.
  task automatic step(input bit rn, input bit br, input bit mds, input bit mr,
                      input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2,
                      input bit u1, input bit u2);
    logic [6:0] exp_ctl;
    @(negedge clk);
    rst_n              = rn;
    hz.EX_branch_taken = br;
    hz.EX_md_start     = mds;
    hz.EX_memread      = mr;
    hz.EX_rd           = rd;
    hz.ID_rs1          = r1;
    hz.ID_rs2          = r2;
    hz.ID_uses_rs1     = u1;
    hz.ID_uses_rs2     = u2;
    #1;
    if (!rn) begin
      exp_ctl = CtlReset;
    end else if (m_md_left > 0) begin
      exp_ctl = CtlMd;
    end else if (br) begin
      exp_ctl = CtlFlush;
    end else if (mds && Lat > 1) begin
      exp_ctl = CtlMd;
    end else if (model_lu(mr, rd, r1, r2, u1, u2)) begin
      exp_ctl = CtlLu;
    end else begin
      exp_ctl = CtlIdle;
    end
    check_eq("ctl", {25'd0, hz.pc_write, hz.ifid_write, hz.ifid_flush, hz.idex_bubble,
                     hz.idex_write, hz.ex_hold, hz.exmem_bubble}, {25'd0, exp_ctl});
    if (m_cnt_known) check_eq("stall_cycles", 32'(hz.stall_cycles), 32'(m_cnt));

    if (!rn) begin
      m_md_left   = 0;
      m_cnt       = 0;
      m_cnt_known = 1'b1;
    end else begin
      if (m_md_left > 0)                 m_md_left--;
      else if (!br && mds && Lat > 1)    m_md_left = Lat - 2;
      if (exp_ctl[6] == 1'b0 && m_cnt < SatMax) m_cnt++;
    end
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  initial begin
    // reset
    step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle();

    // load-use on rs2: one stall cycle, then defaults
    step(1, 0, 0, 1, 5'd5, 5'd1, 5'd5, 0, 1);
    idle();
    check_eq("lu_count", 32'(hz.stall_cycles), 32'd1);

    // x0 destination and unused operand never stall
    step(1, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1);
    step(1, 0, 0, 1, 5'd7, 5'd7, 5'd2, 0, 1);
    idle();
    check_eq("no_stall_count", 32'(hz.stall_cycles), 32'd1);

    // mul/div: Lat-1 = 3 stall cycles
    step(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle();
    idle();
    idle();
    check_eq("md_count", 32'(hz.stall_cycles), 32'd4);

    // branch beats load-use
    step(1, 1, 0, 1, 5'd5, 5'd5, 5'd0, 1, 0);
    idle();
    check_eq("br_lu_count", 32'(hz.stall_cycles), 32'd4);

    // reset on second MD_BUSY cycle
    step(1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle();
    step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle();
    check_eq("md_reset_count", 32'(hz.stall_cycles), 32'd0);
    idle();

    // saturation with continuous load-use
    for (int i = 0; i < 20; i++) step(1, 0, 0, 1, 5'd3, 5'd3, 5'd0, 1, 0);
    idle();
    check_eq("saturate", 32'(hz.stall_cycles), 32'(SatMax));

    // reset then randomised traffic
    step(0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    for (int i = 0; i < 500; i++) begin
      step(($urandom_range(0, 39) != 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
